// File: rtl/uart_agent_pkg.sv
// rtl/uart_agent_pkg.sv - shared types and helpers for the uart_agent block
//
// Contents:
//   parity_e    frame parity mode (none / odd / even)
//   rx_state_e  receiver FSM states
//   tx_state_e  transmitter FSM states
//   rx_entry_t  RX FIFO entry {ferr, perr, data[7:0]}
//   calc_div    clocks per bit, rounded to nearest
//   parity_bit  parity bit value for a (masked) data byte
package uart_agent_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_e;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Bit that makes the total number of ones in data+parity odd or even.
    // Caller passes data with the bits above DATA_BITS already cleared.
    function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
        logic ones;
        ones = ^data;
        case (mode)
            PAR_ODD:  return ~ones;
            PAR_EVEN: return ones;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_agent_fifo.sv
// rtl/uart_agent_fifo.sv - synchronous first-word-fall-through FIFO
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (clears pointers)
//   push_data/push write side; a push on a full FIFO is taken only with a pop
//   pop            read side; ignored when empty
//   head           entry at the read pointer (valid whenever empty=0)
//   full, empty    occupancy flags
module uart_agent_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // On a full FIFO the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_agent.sv
// rtl/uart_agent.sv - full-duplex UART agent with buffered RX and TX
//
// Optional feature macro: UART_AGENT_PRINT_EN (console echo of received frames).
//
// Ports:
//   clk, reset_n          agent clock, asynchronous active-low reset
//   uart_rx               line from the SoC serial_tx
//   uart_tx               line to the SoC serial_rx (registered, idles high)
//   tx_data/valid/ready   TX FIFO push handshake; tx_ready = TX FIFO not full
//   rx_data/perr/ferr     head of the RX FIFO, zero when empty
//   rx_valid/rx_ready     RX FIFO not empty / pop
//   rx_overflow           sticky: a received frame was dropped on a full RX FIFO
//   tx_busy               serializer active or TX FIFO non-empty
module uart_agent
    import uart_agent_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overflow,
    output logic       tx_busy
);

    localparam int DIV   = calc_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int CNT_W = $clog2(STOP_BITS * DIV);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam parity_e          PAR_MODE  = parity_e'(PARITY[1:0]);

    if (DIV < 8) begin : g_bad_div
        $error("uart_agent: CLK_FREQUENCY/BAUD_RATE must give at least 8 clocks per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_agent: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_agent: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_agent: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_agent: FIFO_DEPTH must be a power of two, at least 2");
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // Two-flop synchroniser; rx_prev only serves the falling-edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_e        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_perr_q, rx_perr_n;
    logic             rx_push;
    rx_entry_t        rx_push_entry;

    always_comb begin
        rx_state_n    = rx_state;
        rx_cnt_n      = rx_cnt;
        rx_bit_n      = rx_bit;
        rx_shift_n    = rx_shift;
        rx_perr_n     = rx_perr_q;
        rx_push       = 1'b0;
        rx_push_entry = '0;

        if (rx_state != RX_IDLE && rx_cnt != '0) rx_cnt_n = rx_cnt - 1'b1;

        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_cnt_n   = HALF_LOAD;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_cnt_n   = BIT_LOAD;
                        rx_bit_n   = '0;
                        rx_shift_n = '0;
                        rx_perr_n  = 1'b0;
                        rx_state_n = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n[rx_bit] = rx_sync;
                    rx_cnt_n           = BIT_LOAD;
                    if (rx_bit == LAST_BIT) begin
                        rx_state_n = (PAR_MODE != PAR_NONE) ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end
            end
            RX_PAR: begin
                if (rx_cnt == '0) begin
                    rx_perr_n  = (rx_sync != parity_bit(rx_shift, PAR_MODE));
                    rx_cnt_n   = BIT_LOAD;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                // A second stop bit is simply seen as idle line by RX_IDLE.
                if (rx_cnt == '0) begin
                    rx_push            = 1'b1;
                    rx_push_entry.ferr = ~rx_sync;
                    rx_push_entry.perr = rx_perr_q;
                    rx_push_entry.data = rx_shift;
                    rx_state_n         = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_perr_q <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bit    <= rx_bit_n;
            rx_shift  <= rx_shift_n;
            rx_perr_q <= rx_perr_n;
        end
    end

    logic      rx_full;
    logic      rx_empty;
    logic [9:0] rx_head_bits;
    rx_entry_t rx_head;

    uart_agent_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_data (rx_push_entry),
        .push      (rx_push),
        .pop       (rx_ready),
        .head      (rx_head_bits),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign rx_head  = rx_head_bits;
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_valid ? rx_head.data : 8'h00;
    assign rx_perr  = rx_valid && rx_head.perr;
    assign rx_ferr  = rx_valid && rx_head.ferr;

    // A full FIFO still accepts a frame when the head is popped that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_overflow <= 1'b0;
        end else if (rx_push && rx_full && !rx_ready) begin
            rx_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_pop;

    uart_agent_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_data (tx_data & DATA_MASK),
        .push      (tx_valid && tx_ready),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign tx_ready = !tx_full;

    tx_state_e        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_byte, tx_byte_n;
    logic             tx_par, tx_par_n;
    logic             tx_load;
    logic             tx_line_n;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_byte_n  = tx_byte;
        tx_par_n   = tx_par;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        tx_line_n  = 1'b1;

        if (tx_state != TX_IDLE && tx_cnt != '0) tx_cnt_n = tx_cnt - 1'b1;

        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) tx_load = 1'b1;
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n   = BIT_LOAD;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    if (tx_bit == LAST_BIT) begin
                        if (PAR_MODE != PAR_NONE) begin
                            tx_cnt_n   = BIT_LOAD;
                            tx_state_n = TX_PAR;
                        end else begin
                            tx_cnt_n   = STOP_LOAD;
                            tx_state_n = TX_STOP;
                        end
                    end else begin
                        tx_cnt_n = BIT_LOAD;
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end
            end
            TX_PAR: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n   = STOP_LOAD;
                    tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit: no idle gap.
                if (tx_cnt == '0) begin
                    if (!tx_empty) tx_load = 1'b1;
                    else           tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_byte_n  = tx_head;
            tx_par_n   = parity_bit(tx_head, PAR_MODE);
            tx_cnt_n   = BIT_LOAD;
            tx_state_n = TX_START;
        end

        // uart_tx is registered from the next state so the line and the
        // state change on the same edge.
        case (tx_state_n)
            TX_START: tx_line_n = 1'b0;
            TX_DATA:  tx_line_n = tx_byte_n[tx_bit_n];
            TX_PAR:   tx_line_n = tx_par_n;
            default:  tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_par   <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_byte  <= tx_byte_n;
            tx_par   <= tx_par_n;
            uart_tx  <= tx_line_n;
        end
    end

    assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

`ifdef UART_AGENT_PRINT_EN
    always_ff @(posedge clk) begin
        if (reset_n && rx_push) begin
            $write("%c", rx_push_entry.data);
            if (rx_push_entry.perr || rx_push_entry.ferr) begin
                $display("UART_AGENT: parity/framing error 0x%02h at %0t",
                         rx_push_entry.data, $time);
            end
            if (rx_full && !rx_ready) begin
                $display("UART_AGENT: warning, RX FIFO full, frame 0x%02h dropped at %0t",
                         rx_push_entry.data, $time);
            end
        end
    end
`else
    // Console echo compiled out; datapath is identical.
`endif

endmodule

// File: doc/uart_agent.md
Name: uart_agent

Overview:
- Parametrised successor to the bench UART monitor: full-duplex UART agent with configurable frame format and buffered RX/TX.
- Sits between the SoC `serial_tx`/`serial_rx` pins and bench stimulus/checker logic.
- Decodes SoC transmissions into an RX FIFO with error flags.
- Drives bytes from a TX FIFO toward the SoC; the existing monitor has no transmit path.

Parameters:
- CLK_FREQUENCY, 50_000_000, agent clock frequency in Hz.
- BAUD_RATE, 115200, line rate. DIV = round(CLK_FREQUENCY/BAUD_RATE), minimum 8, checked by elaboration assertion.
- DATA_BITS, 8, data bits per frame, legal range 5..8, LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.
- FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2.

Ports:
- clk  in  1  agent clock.
- reset_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  line from the SoC's serial_tx.
- uart_tx  out  1  line to the SoC's serial_rx.
- tx_data  in  8  byte to send; bits above DATA_BITS are ignored.
- tx_valid  in  1  TX FIFO push request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  8  head of RX FIFO; zero-extended above DATA_BITS.
- rx_perr  out  1  parity error flag of the head entry.
- rx_ferr  out  1  framing error flag of the head entry.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  RX FIFO pop.
- rx_overflow  out  1  sticky; set when a frame is dropped because the RX FIFO is full.
- tx_busy  out  1  serializer active or TX FIFO non-empty.

Behaviour:
- Reset values: uart_tx=1, tx_ready=1, rx_valid=0, rx_data/rx_perr/rx_ferr=0, rx_overflow=0, tx_busy=0.
- Reset clears both FIFOs and returns both FSMs to IDLE.
- Reset asserted mid-frame aborts the frame: uart_tx returns high asynchronously and the partial frame is discarded.
- Handshakes are valid/ready, transfer on rising clk when both are high.
- Push when full: tx_valid with tx_ready=0 is ignored.
- RX FIFO is first-word-fall-through: rx_data/rx_perr/rx_ferr reflect the head whenever rx_valid=1.
- Push and pop in the same cycle are both honoured, on a full or an empty FIFO alike.
  - Exception: RX pop on an empty FIFO is a no-op.
- Pointers wrap modulo FIFO_DEPTH and carry an extra MSB to tell full from empty.
- RX synchroniser: uart_rx passes through 2 flops before any use.
- RX FSM:
  - IDLE: on a 1→0 edge of the synchronised line, load the counter with DIV/2−1 → START.
  - START: at count 0, sample; if the line is 1 (glitch) → IDLE; otherwise reload DIV−1, bit index 0 → DATA.
  - DATA: at each count 0, shift in the sample, LSB first. After DATA_BITS samples → PAR if PARITY≠0, else → STOP.
  - PAR: at count 0, sample; perr = (received parity ≠ computed) → STOP.
  - STOP: at count 0, sample.
    - ferr = sample==0.
    - Only the first stop bit is checked; a second stop bit is tolerated as idle.
    - Push {ferr, perr, data}; if the FIFO is full, drop the frame and set rx_overflow.
    - → IDLE.
- RX latency: the entry becomes visible (rx_valid) 1 cycle after the mid-stop-bit sample.
- Odd/even parity: the computed bit makes the total count of 1s in data+parity odd/even.
- TX FSM:
  - IDLE: if the TX FIFO is non-empty, pop and load the shifter → START. No idle gap is inserted between back-to-back frames.
  - START: uart_tx=0 for DIV cycles → DATA.
  - DATA: send DATA_BITS bits, LSB first, DIV cycles each → PAR (if PARITY≠0) or STOP.
  - PAR: send the parity bit for DIV cycles → STOP.
  - STOP: uart_tx=1 for STOP_BITS×DIV cycles → IDLE.
- uart_tx is registered: the first start-bit cycle is 1 cycle after the pop.
- rx_overflow clears only on reset.

Optional Feature:
- Macro: UART_AGENT_PRINT_EN.
- Defined: on each RX push, `$write` the character.
  - On perr/ferr, `$display` "UART_AGENT: parity/framing error 0x%02h" with the simulation time.
  - On overflow, `$display` a warning.
- Not defined: no system tasks are compiled, and the block is fully synthesisable.
- Functional behaviour is identical either way.

Decomposition:
- Package uart_agent_pkg holds:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN);
  - rx_state_e and tx_state_e;
  - function calc_div(clk, baud) and function parity_bit(data, mode);
  - typedef rx_entry_t {ferr, perr, data[7:0]}.
- One natural sub-module: uart_agent_fifo (parametrised width/depth, FWFT, sync), instantiated for both RX and TX.

Test Plan:
- Config CLK_FREQUENCY=1_000_000, BAUD_RATE=100_000 (DIV=10), 8N1. Drive frame 0x55 on uart_rx → rx_valid high 1 cycle after the stop-bit mid-sample, rx_data=0x55, perr=0, ferr=0.
- PARITY=2 (even), send 0x07 with parity bit 0 (wrong) → rx_perr=1, rx_data=0x07. Repeat with parity 1 → rx_perr=0.
- 4-cycle low glitch on uart_rx → FSM returns to IDLE, no push, rx_valid stays 0.
- Stop bit driven 0 on byte 0xA3 → rx_ferr=1 with rx_data=0xA3.
- FIFO_DEPTH=4, rx_ready=0, send 5 frames → first 4 entries retained in order, rx_overflow=1. Pop one while a frame completes in the same cycle → count stays 4.
- DATA_BITS=7, PARITY=1, STOP_BITS=2; push 0x41, 0x42 back-to-back on TX:
  - uart_tx shows start, 1000001, parity 1, then 20 cycles high, then the next start bit;
  - tx_busy=0 after the last stop bit;
  - reset_n pulsed mid-frame → uart_tx=1 immediately.
